// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM state encoding and the scoreboard lookup helper for the
// pipeline interlock controller.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_WD = 5;
    localparam int REG_NUM     = 32;
    localparam int LOAD_CNT_WD = 3;

    typedef enum logic [1:0] {
        HC_RUN      = 2'd0,
        HC_REDIRECT = 2'd1,
        HC_HALT     = 2'd2
    } hc_state_e;

    // A source hits only if it is read, pending, and not retiring from WB this
    // cycle (the WB bypass already supplies that value).
    function automatic logic src_hit(
        input logic [REG_NUM-1:0]     sb,
        input logic [REG_ADDR_WD-1:0] idx,
        input logic                   used,
        input logic                   clr_vld,
        input logic [REG_ADDR_WD-1:0] clr_rd
    );
        return used & sb[idx] & ~(clr_vld & (clr_rd == idx));
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_scoreboard.sv
// Per-register pending-load scoreboard plus in-flight load counter; produces
// the combinational load-use (raw) and tracker-full stall terms.
module load_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_LOADS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_vld,
    input  logic [REG_ADDR_WD-1:0] set_rd,
    input  logic                   clr_vld,
    input  logic [REG_ADDR_WD-1:0] clr_rd,
    input  logic [REG_ADDR_WD-1:0] rs1,
    input  logic                   rs1_used,
    input  logic [REG_ADDR_WD-1:0] rs2,
    input  logic                   rs2_used,
    input  logic                   is_load,
    output logic                   raw,
    output logic                   full,
    output logic [LOAD_CNT_WD-1:0] load_cnt
);

    logic [REG_NUM-1:0]     sb_q, sb_d;
    logic [LOAD_CNT_WD-1:0] cnt_q, cnt_d;
    logic                   dec;

    // Set is applied after clear so a younger load to the same register keeps ownership.
    always_comb begin
        sb_d = sb_q;
        if (clr_vld) sb_d[clr_rd] = 1'b0;
        if (set_vld && (set_rd != '0)) sb_d[set_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    assign dec = clr_vld && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (set_vld && !dec)      cnt_d = cnt_q + 1'b1;
        else if (!set_vld && dec) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign raw = src_hit(sb_q, rs1, rs1_used, clr_vld, clr_rd)
               | src_hit(sb_q, rs2, rs2_used, clr_vld, clr_rd);
    assign full = is_load && (cnt_q == LOAD_CNT_WD'(MAX_LOADS)) && !clr_vld;
    assign load_cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: load-use / tracker-full stall of ID, fetch-kill window
// after a taken redirect, and sticky freeze on a retired ebreak.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_LOADS       = 2,
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_WD-1:0] id_rs1,
    input  logic [REG_ADDR_WD-1:0] id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [REG_ADDR_WD-1:0] id_rd,
    input  logic                   id_is_load,
    input  logic                   exe_allowin,
    input  logic                   id_br_jmp,
    input  logic                   wb_valid,
    input  logic                   wb_is_load,
    input  logic [REG_ADDR_WD-1:0] wb_rd,
    input  logic                   wb_ebreak,
    output logic                   id_ready_go,
    output logic                   id_fire,
    output logic                   if_kill,
    output logic                   halted,
    output logic [LOAD_CNT_WD-1:0] load_cnt
);

    hc_state_e   state_q;
    logic [1:0]  rcnt_q;
    logic        if_kill_q;
    logic        halted_q;
    logic        raw, full;
    logic        wb_load, ebreak;

    assign wb_load = wb_valid & wb_is_load;
    assign ebreak  = wb_valid & wb_ebreak;

    load_scoreboard #(
        .MAX_LOADS (MAX_LOADS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_vld  (id_fire & id_is_load),
        .set_rd   (id_rd),
        .clr_vld  (wb_load),
        .clr_rd   (wb_rd),
        .rs1      (id_rs1),
        .rs1_used (id_rs1_used),
        .rs2      (id_rs2),
        .rs2_used (id_rs2_used),
        .is_load  (id_is_load),
        .raw      (raw),
        .full     (full),
        .load_cnt (load_cnt)
    );

    assign id_ready_go = !raw && !full && (state_q == HC_RUN);
    assign id_fire     = id_valid && id_ready_go && exe_allowin;
    assign if_kill     = if_kill_q;
    assign halted      = halted_q;

    // rcnt_q holds the remaining extra kill cycles; REDIRECT lasts rcnt+1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HC_RUN;
            rcnt_q    <= '0;
            if_kill_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            unique case (state_q)
                HC_RUN: begin
                    if (ebreak) begin
                        state_q   <= HC_HALT;
                        if_kill_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else if (id_fire && id_br_jmp) begin
                        state_q   <= HC_REDIRECT;
                        rcnt_q    <= 2'(REDIRECT_CYCLES - 1);
                        if_kill_q <= 1'b1;
                    end
                end
                HC_REDIRECT: begin
                    if (ebreak) begin
                        state_q   <= HC_HALT;
                        if_kill_q <= 1'b1;
                        halted_q  <= 1'b1;
                    end else if (rcnt_q == '0) begin
                        state_q   <= HC_RUN;
                        if_kill_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_q - 1'b1;
                    end
                end
                HC_HALT: begin
                    if_kill_q <= 1'b1;
                    halted_q  <= 1'b1;
                end
                default: begin
                    state_q   <= HC_RUN;
                    if_kill_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
